// File: rtl/johnson_phase_decoder_pkg.sv
// Shared types and helpers for the Johnson phase decoder: lock FSM states,
// phase-count and index-width sizing, and the phase successor.
package johnson_dec_pkg;

    typedef enum logic [1:0] {
        UNLOCKED,
        ACQUIRE,
        LOCKED
    } lock_state_t;

    function automatic int ph_count(input int width);
        return 2 * width;
    endfunction

    function automatic int idx_w(input int width);
        return $clog2(2 * width);
    endfunction

    function automatic int succ(input int p, input int ph);
        return (p + 1) % ph;
    endfunction

endpackage

// File: rtl/johnson_phase_decoder_if.sv
// Code input and decoded-output bundle of the Johnson phase decoder.
interface johnson_phase_decoder_if
    import johnson_dec_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    localparam int PH = ph_count(WIDTH);
    localparam int PW = idx_w(WIDTH);

    logic [WIDTH-1:0] q_in;
    logic             err_clr;
    logic [PW-1:0]    phase;
    logic [PH-1:0]    phase_onehot;
    logic             step;
    logic             wrap;
    logic             fault;
    logic             locked;
    logic [ERR_W-1:0] err_count;

    modport master (
        output q_in, err_clr,
        input  phase, phase_onehot, step, wrap, fault, locked, err_count
    );

    modport slave (
        input  q_in, err_clr,
        output phase, phase_onehot, step, wrap, fault, locked, err_count
    );

endinterface

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code to {legal, phase}. Illegal codes report phase 0.
module johnson_code_decode
    import johnson_dec_pkg::*;
#(
    parameter int  WIDTH = 4,
    localparam int PH    = ph_count(WIDTH),
    localparam int PW    = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] q,
    output logic             legal,
    output logic [PW-1:0]    phase
);

    logic [WIDTH-1:0] cand;

    // Phases 0..WIDTH fill ones from the bottom; later phases clear from the bottom.
    always_comb begin
        legal = 1'b0;
        phase = '0;
        cand  = '0;
        for (int p = 0; p < PH; p++) begin
            for (int i = 0; i < WIDTH; i++)
                cand[i] = (p <= WIDTH) ? (i < p) : (i >= p - WIDTH);
            if (q == cand) begin
                legal = 1'b1;
                phase = PW'(p);
            end
        end
    end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Johnson code checker/decoder with lock FSM. Define JOHNSON_DEC_ERRCNT_EN
// to build the saturating fault counter; otherwise err_count is tied to 0.
module johnson_phase_decoder
    import johnson_dec_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    johnson_phase_decoder_if.slave  bus
);

    localparam int PH = ph_count(WIDTH);
    localparam int PW = idx_w(WIDTH);
    localparam int CW = 8;

    logic          dec_legal;
    logic [PW-1:0] dec_phase;
    logic [PW-1:0] prev_phase;
    logic          prev_valid;
    lock_state_t   state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          is_step;
    logic          is_fault;

    johnson_code_decode #(.WIDTH(WIDTH)) u_dec (
        .q     (bus.q_in),
        .legal (dec_legal),
        .phase (dec_phase)
    );

    // Hold and first-sample cases leave both flags clear.
    always_comb begin
        is_step  = 1'b0;
        is_fault = 1'b0;
        if (!dec_legal)
            is_fault = 1'b1;
        else if (prev_valid && dec_phase != prev_phase) begin
            if (dec_phase == PW'(succ(int'(prev_phase), PH)))
                is_step = 1'b1;
            else
                is_fault = 1'b1;
        end
    end

    assign cnt_nxt = cnt + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_valid       <= 1'b0;
            prev_phase       <= '0;
            bus.phase        <= '0;
            bus.phase_onehot <= '0;
            bus.step         <= 1'b0;
            bus.wrap         <= 1'b0;
            bus.fault        <= 1'b0;
        end else begin
            prev_valid <= dec_legal;
            if (dec_legal)
                prev_phase <= dec_phase;
            bus.phase        <= dec_phase;
            bus.phase_onehot <= dec_legal ? (PH'(1) << dec_phase) : '0;
            bus.step         <= is_step;
            bus.wrap         <= is_step && (dec_phase == '0);
            bus.fault        <= is_fault;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= UNLOCKED;
            cnt        <= '0;
            bus.locked <= 1'b0;
        end else begin
            case (state)
                UNLOCKED: if (dec_legal && !is_fault) begin
                    state <= ACQUIRE;
                    cnt   <= '0;
                end
                ACQUIRE: if (is_fault) begin
                    state <= UNLOCKED;
                    cnt   <= '0;
                end else if (is_step) begin
                    cnt <= cnt_nxt;
                    if (cnt_nxt == CW'(LOCK_COUNT)) begin
                        state      <= LOCKED;
                        bus.locked <= 1'b1;
                    end
                end
                LOCKED: if (is_fault) begin
                    state      <= UNLOCKED;
                    cnt        <= '0;
                    bus.locked <= 1'b0;
                end
                default: begin
                    state      <= UNLOCKED;
                    bus.locked <= 1'b0;
                end
            endcase
        end
    end

`ifdef JOHNSON_DEC_ERRCNT_EN
    // Clear beats a coincident fault.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bus.err_count <= '0;
        else if (bus.err_clr)
            bus.err_count <= '0;
        else if (is_fault && bus.err_count != '1)
            bus.err_count <= bus.err_count + ERR_W'(1);
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign bus.err_count  = '0;
`endif

endmodule
